// File: rtl/lbp_hist_comparator.sv
// L1 nearest-neighbour matcher: streams the test histogram and every trained
// histogram from the shared RAM, keeps the minimum distance and reports its ID.
module lbp_hist_comparator #(
  parameter int          N_BINS    = 256,
  parameter int          BIN_W     = 8,
  parameter int          MAX_FACES = 32,
  parameter logic [15:0] TEST_BASE = 16'hF000,
  localparam int         ACC_W     = BIN_W + $clog2(N_BINS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             comparator_enable,
  input  logic [7:0]       num_faces,
  output logic [15:0]      hist_addr,
  output logic             hist_ren,
  input  logic [BIN_W-1:0] hist_rdata,
  output logic [7:0]       id_addr,
  input  logic [4:0]       id_rdata,
  output logic             comparator_finish,
  output logic [4:0]       result_id,
  output logic [ACC_W-1:0] result_dist,
  output logic             no_match,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  localparam int B_W = $clog2(N_BINS);

  // Protocol: comparator_enable is a one-cycle start pulse honoured only in
  // IDLE; both RAMs return data one cycle after the address is presented;
  // comparator_finish is a one-cycle pulse with result_* valid alongside it.
  typedef enum logic [2:0] {
    S_IDLE, S_RD_TEST, S_RD_TRAIN, S_FACE_END, S_RD_ID, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [B_W-1:0]   bin;
  logic [7:0]       face, nf, best_idx;
  logic [BIN_W-1:0] test_word, abs_diff;
  logic [ACC_W-1:0] acc, best_dist, face_dist;
  logic [7:0]       nf_clamped;

  assign nf_clamped = (num_faces > 8'(MAX_FACES)) ? 8'(MAX_FACES) : num_faces;
  assign abs_diff   = (test_word >= hist_rdata) ? (test_word - hist_rdata)
                                                : (hist_rdata - test_word);
  assign face_dist  = acc + ACC_W'(abs_diff);
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hist_ren  = 1'b0;
    hist_addr = 16'd0;
    id_addr   = 8'd0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (comparator_enable)
          state_nxt = (num_faces == 8'd0) ? S_RD_ID : S_RD_TEST;
      end
      S_RD_TEST: begin
        hist_ren  = 1'b1;
        hist_addr = TEST_BASE + 16'(bin);
        state_nxt = S_RD_TRAIN;
      end
      S_RD_TRAIN: begin
        hist_ren  = 1'b1;
        hist_addr = (16'(face) << B_W) + 16'(bin);
        state_nxt = (bin == B_W'(N_BINS - 1)) ? S_FACE_END : S_RD_TEST;
      end
      S_FACE_END: begin
        state_nxt = (({1'b0, face} + 9'd1) < {1'b0, nf}) ? S_RD_TEST : S_RD_ID;
      end
      S_RD_ID: begin
        id_addr   = best_idx;
        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin               <= '0;
      face              <= '0;
      nf                <= '0;
      best_idx          <= '0;
      test_word         <= '0;
      acc               <= '0;
      best_dist         <= '0;
      comparator_finish <= 1'b0;
      result_id         <= '0;
      result_dist       <= '0;
      no_match          <= 1'b0;
    end else begin
      comparator_finish <= 1'b0;
      case (state)
        S_IDLE: begin
          if (comparator_enable) begin
            nf       <= nf_clamped;
            face     <= '0;
            bin      <= '0;
            acc      <= '0;
            best_idx <= '0;
          end
        end
        S_RD_TEST: begin
          // hist_rdata holds the train word of the previous bin here
          if (bin != '0) acc <= face_dist;
        end
        S_RD_TRAIN: begin
          test_word <= hist_rdata;
          bin       <= bin + B_W'(1);
        end
        S_FACE_END: begin
          if (face == 8'd0 || face_dist < best_dist) begin
            best_dist <= face_dist;
            best_idx  <= face;
          end
          acc  <= '0;
          face <= face + 8'd1;
        end
        S_DONE: begin
          comparator_finish <= 1'b1;
          if (nf == 8'd0) begin
            no_match    <= 1'b1;
            result_dist <= '1;
            result_id   <= '0;
          end else begin
            no_match    <= 1'b0;
            result_dist <= best_dist;
            result_id   <= id_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_hist_comparator.sv
// Bench for lbp_hist_comparator: RAM models plus a loop-based nearest-match
// reference computed directly from the stored histograms.
module tb_lbp_hist_comparator;

  localparam int          N_BINS    = 4;
  localparam int          BIN_W     = 8;
  localparam int          MAX_FACES = 32;
  localparam logic [15:0] TEST_BASE = 16'hF000;
  localparam int          ACC_W     = BIN_W + $clog2(N_BINS);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             comparator_enable = 1'b0;
  logic [7:0]       num_faces = 8'd0;
  logic [15:0]      hist_addr;
  logic             hist_ren;
  logic [BIN_W-1:0] hist_rdata = '0;
  logic [7:0]       id_addr;
  logic [4:0]       id_rdata = '0;
  logic             comparator_finish;
  logic [4:0]       result_id;
  logic [ACC_W-1:0] result_dist;
  logic             no_match;
  logic             busy;
  logic [2:0]       dbg_state;

  lbp_hist_comparator #(
    .N_BINS(N_BINS), .BIN_W(BIN_W), .MAX_FACES(MAX_FACES), .TEST_BASE(TEST_BASE)
  ) dut (
    .clk(clk), .rst(rst), .comparator_enable(comparator_enable),
    .num_faces(num_faces), .hist_addr(hist_addr), .hist_ren(hist_ren),
    .hist_rdata(hist_rdata), .id_addr(id_addr), .id_rdata(id_rdata),
    .comparator_finish(comparator_finish), .result_id(result_id),
    .result_dist(result_dist), .no_match(no_match), .busy(busy),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [BIN_W-1:0] hist_mem [0:65535];
  logic [4:0]       id_mem   [0:255];

  always @(posedge clk) begin
    if (hist_ren) hist_rdata <= hist_mem[hist_addr];
    id_rdata <= id_mem[id_addr];
  end

  int n_cmp = 0;
  int n_fail = 0;
  int ren_cnt = 0;
  int max_face = -1;
  int fin_cnt = 0;
  logic [7:0] id_d1 = '0, id_d2 = '0;

  always @(negedge clk) begin
    if (hist_ren) begin
      ren_cnt++;
      if (hist_addr < TEST_BASE && int'(hist_addr) / N_BINS > max_face)
        max_face = int'(hist_addr) / N_BINS;
    end
    if (comparator_finish) fin_cnt++;
    id_d2 = id_d1;
    id_d1 = id_addr;
  end

  task automatic set_test(input int v);
    for (int b = 0; b < N_BINS; b++) hist_mem[TEST_BASE + 16'(b)] = BIN_W'(v);
  endtask

  // Face k gets bin 0 = d, other bins 0; with a zero test histogram its distance is d.
  task automatic set_face(input int k, input int d, input int id);
    for (int b = 0; b < N_BINS; b++) hist_mem[k * N_BINS + b] = (b == 0) ? BIN_W'(d) : '0;
    id_mem[k] = 5'(id);
  endtask

  task automatic run_case(input string name, input int f_req, input bit poke_busy);
    int f, best_i, best_d, d, cyc, fin0;
    bit got;
    logic [ACC_W-1:0] exp_dist;
    logic [4:0] exp_id, held_id;
    logic [ACC_W-1:0] held_dist;
    f = (f_req > MAX_FACES) ? MAX_FACES : f_req;
    best_i = 0;
    best_d = -1;
    for (int k = 0; k < f; k++) begin
      d = 0;
      for (int b = 0; b < N_BINS; b++) begin
        int t, r;
        t = int'(hist_mem[TEST_BASE + 16'(b)]);
        r = int'(hist_mem[k * N_BINS + b]);
        d += (t > r) ? t - r : r - t;
      end
      if (best_d < 0 || d < best_d) begin best_d = d; best_i = k; end
    end
    exp_dist = (f == 0) ? '1 : ACC_W'(best_d);
    exp_id   = (f == 0) ? 5'd0 : id_mem[best_i];

    ren_cnt = 0;
    max_face = -1;
    fin0 = fin_cnt;
    @(negedge clk);
    num_faces = 8'(f_req);
    comparator_enable = 1'b1;
    @(posedge clk);
    #1 comparator_enable = 1'b0;
    cyc = 0;
    got = 0;
    while (!got && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (poke_busy && (cyc == 3 || cyc == 6)) begin
        comparator_enable = 1'b1;
        num_faces = 8'd0;
      end else if (poke_busy) begin
        comparator_enable = 1'b0;
      end
      if (comparator_finish) got = 1;
    end
    comparator_enable = 1'b0;
    num_faces = 8'(f_req);

    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s timeout: no finish after %0d cycles, required at %0d", name, cyc, f * (2 * N_BINS + 1) + 2);
      return;
    end
    n_cmp++;
    if (cyc != f * (2 * N_BINS + 1) + 2) begin
      n_fail++;
      $display("FAIL %s finish_cycle: got %0d required %0d", name, cyc, f * (2 * N_BINS + 1) + 2);
    end
    n_cmp++;
    if (result_id !== exp_id) begin
      n_fail++;
      $display("FAIL %s result_id: got %0d required %0d", name, result_id, exp_id);
    end
    n_cmp++;
    if (result_dist !== exp_dist) begin
      n_fail++;
      $display("FAIL %s result_dist: got %0d required %0d", name, result_dist, exp_dist);
    end
    n_cmp++;
    if (no_match !== (f == 0)) begin
      n_fail++;
      $display("FAIL %s no_match: got %0b required %0b", name, no_match, (f == 0));
    end
    n_cmp++;
    if (ren_cnt != f * 2 * N_BINS || max_face != f - 1) begin
      n_fail++;
      $display("FAIL %s scan: ren cycles %0d last face %0d, required %0d / %0d", name, ren_cnt, max_face, f * 2 * N_BINS, f - 1);
    end
    if (f > 0) begin
      n_cmp++;
      if (id_d2 !== 8'(best_i)) begin
        n_fail++;
        $display("FAIL %s id_addr: got %0d required %0d", name, id_d2, best_i);
      end
    end
    held_id = result_id;
    held_dist = result_dist;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (comparator_finish !== 1'b0 || busy !== 1'b0 || fin_cnt - fin0 != 1 ||
        result_id !== held_id || result_dist !== held_dist) begin
      n_fail++;
      $display("FAIL %s after_finish: finish=%0b busy=%0b pulses=%0d id=%0d dist=%0d, required 0/0/1/%0d/%0d",
               name, comparator_finish, busy, fin_cnt - fin0, result_id, result_dist, held_id, held_dist);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({hist_addr, hist_ren, id_addr, comparator_finish, result_id, result_dist, no_match, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got addr=%0h ren=%0b id_addr=%0d fin=%0b id=%0d dist=%0d nm=%0b busy=%0b, required all 0",
               hist_addr, hist_ren, id_addr, comparator_finish, result_id, result_dist, no_match, busy);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    for (int b = 0; b < N_BINS; b++) begin
      hist_mem[TEST_BASE + 16'(b)] = BIN_W'(b + 1);
      hist_mem[b] = BIN_W'(b + 1);
    end
    id_mem[0] = 5'd7;
    run_case("exact_match", 1, 0);
    set_test(0);
    set_face(0, 10, 4); set_face(1, 3, 9); set_face(2, 7, 2);
    run_case("three_faces", 3, 0);
    set_face(0, 5, 11); set_face(1, 8, 12); set_face(2, 5, 13);
    run_case("tie_lower_index", 3, 0);
  endtask

  task automatic test_no_faces();
    run_case("no_faces", 0, 0);
  endtask

  task automatic test_extremes();
    set_test(255);
    for (int b = 0; b < N_BINS; b++) hist_mem[b] = '0;
    id_mem[0] = 5'd21;
    run_case("max_distance", 1, 0);
    set_test(0);
    for (int k = 0; k < 40; k++) set_face(k, 50 + k, k % 32);
    set_face(35, 0, 30);
    run_case("clamp_40", 40, 0);
  endtask

  task automatic test_busy_enable();
    set_test(0);
    set_face(0, 9, 3); set_face(1, 4, 6);
    run_case("enable_while_busy", 2, 1);
  endtask

  task automatic test_mid_reset();
    int fin0;
    set_face(0, 9, 3); set_face(1, 4, 6);
    fin0 = fin_cnt;
    @(negedge clk);
    num_faces = 8'd2;
    comparator_enable = 1'b1;
    @(posedge clk);
    #1 comparator_enable = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({hist_addr, hist_ren, id_addr, comparator_finish, result_id, result_dist, no_match, busy} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_values: got addr=%0h ren=%0b id=%0d dist=%0d busy=%0b, required all 0",
               hist_addr, hist_ren, result_id, result_dist, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (fin_cnt != fin0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_no_finish: pulses=%0d busy=%0b, required 0/0", fin_cnt - fin0, busy);
    end
    run_case("after_reset", 2, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int f, hi;
      f = $urandom_range(0, 6);
      hi = (r % 2 == 0) ? 3 : 255;
      for (int b = 0; b < N_BINS; b++) hist_mem[TEST_BASE + 16'(b)] = BIN_W'($urandom_range(0, hi));
      for (int k = 0; k < f; k++) begin
        for (int b = 0; b < N_BINS; b++) hist_mem[k * N_BINS + b] = BIN_W'($urandom_range(0, hi));
        id_mem[k] = 5'($urandom_range(0, 31));
      end
      run_case($sformatf("random_%0d", r), f, 0);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) hist_mem[a] = '0;
    for (int a = 0; a < 256; a++) id_mem[a] = 5'(a);
    test_reset();
    test_directed();
    test_no_faces();
    test_extremes();
    test_busy_enable();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
